// File: rtl/emu_host_transactor.sv
// Host-side sequencer for a co-emulation wrapper: collects one stimulus vector from the
// host byte stream, loads/steps/captures the wrapped DUT and streams the output bytes back.
module emu_host_transactor #(
  parameter int NUM_STIM = 1,
  parameter int NUM_OUT  = 3,
  parameter int SETTLE   = 4
) (
  input  logic        clk_emu,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  Din_emu,
  output logic [2:0]  Addr_emu,
  output logic        load_emu,
  output logic        get_emu,
  input  logic [7:0]  Dout_emu,
  output logic        dut_step,
  output logic        busy,
  output logic [15:0] vec_count
);

  localparam logic [3:0] STIM_N   = 4'(NUM_STIM);
  localparam logic [3:0] OUT_N    = 4'(NUM_OUT);
  localparam logic [7:0] SETTLE_N = 8'(SETTLE);

  typedef enum logic [3:0] {
    S_IDLE, S_WR, S_RXW, S_LOAD, S_STEP, S_SETTLE, S_GET, S_RADDR, S_RDATA, S_TX
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  idx_reg, idx_next;
  logic [3:0]  idx_inc;
  logic [7:0]  din_reg, din_next;
  logic [2:0]  addr_reg, addr_next;
  logic [7:0]  settle_reg, settle_next;
  logic [7:0]  txd_reg, txd_next;
  logic        txv_reg, txv_next;
  logic        rdy_reg, rdy_next;
  logic [15:0] vec_count_reg, vec_count_next;

  assign idx_inc = idx_reg + 4'd1;

  always_ff @(posedge clk_emu or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      idx_reg       <= 4'd0;
      din_reg       <= 8'd0;
      addr_reg      <= 3'd0;
      settle_reg    <= 8'd0;
      txd_reg       <= 8'd0;
      txv_reg       <= 1'b0;
      rdy_reg       <= 1'b0;
      vec_count_reg <= 16'd0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      din_reg       <= din_next;
      addr_reg      <= addr_next;
      settle_reg    <= settle_next;
      txd_reg       <= txd_next;
      txv_reg       <= txv_next;
      rdy_reg       <= rdy_next;
      vec_count_reg <= vec_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    din_next       = din_reg;
    addr_next      = addr_reg;
    settle_next    = settle_reg;
    txd_next       = txd_reg;
    txv_next       = txv_reg;
    vec_count_next = vec_count_reg;
    case (state_reg)
      S_IDLE: begin
        idx_next = 4'd0;
        if (rx_valid && rdy_reg) begin
          din_next   = rx_data;
          addr_next  = 3'd0;
          state_next = S_WR;
        end
      end
      S_WR: begin
        idx_next   = idx_inc;
        state_next = (idx_inc == STIM_N) ? S_LOAD : S_RXW;
      end
      S_RXW: begin
        if (rx_valid && rdy_reg) begin
          din_next   = rx_data;
          addr_next  = idx_reg[2:0];
          state_next = S_WR;
        end
      end
      S_LOAD: state_next = S_STEP;
      S_STEP: begin
        settle_next = SETTLE_N;
        state_next  = S_SETTLE;
      end
      S_SETTLE: begin
        // GET follows the cycle in which the counter reaches zero.
        settle_next = settle_reg - 8'd1;
        if (settle_reg <= 8'd1) state_next = S_GET;
      end
      S_GET: begin
        idx_next   = 4'd0;
        addr_next  = 3'd0;
        state_next = S_RADDR;
      end
      S_RADDR: state_next = S_RDATA;
      S_RDATA: begin
        txd_next   = Dout_emu;
        txv_next   = 1'b1;
        state_next = S_TX;
      end
      S_TX: begin
        if (tx_ready) begin
          txv_next = 1'b0;
          idx_next = idx_inc;
          if (idx_inc == OUT_N) begin
            vec_count_next = vec_count_reg + 16'd1;
            state_next     = S_IDLE;
          end else begin
            addr_next  = idx_inc[2:0];
            state_next = S_RADDR;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
    // Registered so that rx_ready reads 0 while reset is applied.
    rdy_next = (state_next == S_IDLE) || (state_next == S_RXW);
  end

  assign rx_ready  = rdy_reg;
  assign tx_data   = txd_reg;
  assign tx_valid  = txv_reg;
  assign Din_emu   = din_reg;
  assign Addr_emu  = addr_reg;
  assign load_emu  = (state_reg == S_LOAD);
  assign get_emu   = (state_reg == S_GET);
  assign dut_step  = (state_reg == S_STEP);
  assign busy      = (state_reg != S_IDLE);
  assign vec_count = vec_count_reg;

endmodule

// File: tb/tb_emu_host_transactor.sv
// Bench for emu_host_transactor: stub wrapper holding a wall-clock DUT (or an address
// pattern), an arithmetic reference model with a byte scoreboard, and directed vectors.
module tb_emu_host_transactor;
  localparam int NUM_STIM = 4;
  localparam int NUM_OUT  = 3;
  localparam int SETTLE   = 4;

  logic        clk_emu = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  Din_emu;
  logic [2:0]  Addr_emu;
  logic        load_emu;
  logic        get_emu;
  logic [7:0]  Dout_emu = 8'h00;
  logic        dut_step;
  logic        busy;
  logic [15:0] vec_count;

  always #5 clk_emu = ~clk_emu;

  emu_host_transactor #(.NUM_STIM(NUM_STIM), .NUM_OUT(NUM_OUT), .SETTLE(SETTLE)) dut (
    .clk_emu(clk_emu), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .Din_emu(Din_emu), .Addr_emu(Addr_emu), .load_emu(load_emu), .get_emu(get_emu),
    .Dout_emu(Dout_emu), .dut_step(dut_step), .busy(busy), .vec_count(vec_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Stub wrapper: stimIn writes, registered read-back, and a wall clock as the wrapped DUT
  // (stim[0] bit0 = count enable, stim[1..3] = preset hh/mm/ss).
  logic [7:0] stim [0:7];
  logic [7:0] cap  [0:7];
  logic [7:0] hh = 8'h00, mm = 8'h00, ss = 8'h00;
  logic       en = 1'b0;
  logic       pat_mode = 1'b0;

  initial for (int i = 0; i < 8; i++) begin stim[i] = 8'h00; cap[i] = 8'h00; end

  always @(posedge clk_emu) begin
    if (!load_emu && !get_emu) stim[Addr_emu] <= Din_emu;
    Dout_emu <= pat_mode ? (8'hA0 + {5'h0, Addr_emu}) : cap[Addr_emu];
    if (load_emu) begin
      en <= stim[0][0]; hh <= stim[1]; mm <= stim[2]; ss <= stim[3];
    end
    if (dut_step && en) begin
      if (ss == 8'd59) begin
        ss <= 8'd0;
        if (mm == 8'd59) begin
          mm <= 8'd0;
          hh <= (hh == 8'd23) ? 8'd0 : hh + 8'd1;
        end else mm <= mm + 8'd1;
      end else ss <= ss + 8'd1;
    end
    if (get_emu) begin cap[0] <= hh; cap[1] <= mm; cap[2] <= ss; end
  end

  // Reference model: one clock step applied to the preset time, in seconds-of-day.
  function automatic logic [23:0] clock_model(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2, input logic [7:0] b3);
    int tot;
    tot = int'(b1) * 3600 + int'(b2) * 60 + int'(b3) + int'(b0[0]);
    tot = tot % 86400;
    return {8'(tot / 3600), 8'((tot / 60) % 60), 8'(tot % 60)};
  endfunction

  logic [7:0] sent [0:3];
  logic [7:0] exp_q [$];
  logic [15:0] vec_exp = 16'd0;

  // Compare process: protocol timing, tx hold rules and scoreboard on every cycle.
  int cyc = 0, load_cyc = 0, step_cyc = 0, rx_acc = 0;
  bit first_pend = 1'b0, hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [2:0] prev_addr = 3'd0;

  always @(negedge clk_emu) begin
    cyc++;
    if (!rst_n) begin
      rx_acc = 0; first_pend = 1'b0; hold = 1'b0; exp_q.delete();
    end else begin
      chk("strobe_exclusive", 32'(load_emu & get_emu), 32'd0);
      if (rx_valid && rx_ready) rx_acc++;
      if (load_emu) begin
        chk("load_after_all_bytes", rx_acc, NUM_STIM);
        rx_acc = 0;
        for (int i = 0; i < NUM_STIM; i++) chk("stim_recorded", stim[i], sent[i]);
        load_cyc = cyc; first_pend = 1'b1;
      end
      if (dut_step) begin
        chk("step_after_load", cyc - load_cyc, 1);
        step_cyc = cyc;
      end
      if (get_emu) chk("get_after_step", cyc - step_cyc, SETTLE + 1);
      if (tx_valid && first_pend) begin
        chk("first_tx_latency", cyc - load_cyc, 5 + SETTLE);
        first_pend = 1'b0;
      end
      if (hold) begin
        chk("tx_hold_valid", 32'(tx_valid), 32'd1);
        chk("tx_hold_data", tx_data, prev_data);
        chk("tx_hold_addr", Addr_emu, prev_addr);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_unexpected actual=0x%0h required=none", tx_data);
        end else chk("tx_byte", tx_data, exp_q.pop_front());
      end
      hold = tx_valid && !tx_ready;
      prev_data = tx_data;
      prev_addr = Addr_emu;
    end
  end

  task automatic send_vec(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input int gap_step);
    logic [23:0] m;
    logic [7:0] b [0:3];
    bit acc;
    int n;
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    for (int i = 0; i < 4; i++) sent[i] = b[i];
    if (pat_mode) begin
      for (int i = 0; i < NUM_OUT; i++) exp_q.push_back(8'hA0 + 8'(i));
    end else begin
      m = clock_model(b0, b1, b2, b3);
      exp_q.push_back(m[23:16]); exp_q.push_back(m[15:8]); exp_q.push_back(m[7:0]);
    end
    for (int i = 0; i < NUM_STIM; i++) begin
      repeat (i * gap_step) begin @(posedge clk_emu); #1; end
      rx_data = b[i]; rx_valid = 1'b1;
      n = 0; acc = 1'b0;
      while (!acc && n < 200) begin
        @(negedge clk_emu); acc = rx_ready;
        @(posedge clk_emu); #1; n++;
      end
      rx_valid = 1'b0;
      if (!acc) begin
        checks++; failures++;
        $display("FAIL rx_accept_timeout actual=not_ready required=ready byte=%0d", i);
      end
    end
  endtask

  task automatic recv_vec(input int stall_len, output logic [7:0] g0, output logic [7:0] g1,
                          output logic [7:0] g2);
    logic [7:0] got [0:2];
    int n;
    for (int k = 0; k < NUM_OUT; k++) begin
      got[k] = 8'h00;
      if (k == 1 && stall_len > 0) tx_ready = 1'b0;
      n = 0;
      while (!tx_valid && n < 200) begin @(posedge clk_emu); #1; n++; end
      if (!tx_valid) begin
        checks++; failures++;
        $display("FAIL tx_valid_timeout actual=0 required=1 byte=%0d", k);
      end else begin
        if (k == 1 && stall_len > 0) begin
          repeat (stall_len) begin @(posedge clk_emu); #1; end
          tx_ready = 1'b1;
        end
        got[k] = tx_data;
        @(posedge clk_emu); #1;
      end
    end
    tx_ready = 1'b1;
    g0 = got[0]; g1 = got[1]; g2 = got[2];
  endtask

  task automatic run_vec(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3, input int gap_step,
                         input int stall_len, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2);
    logic [7:0] g0, g1, g2;
    send_vec(b0, b1, b2, b3, gap_step);
    recv_vec(stall_len, g0, g1, g2);
    vec_exp = vec_exp + 16'd1;
    $display("vec %s in=%02h %02h %02h %02h out=%02h %02h %02h vec_count=%0h",
             tag, b0, b1, b2, b3, g0, g1, g2, vec_count);
    chk({tag, "_byte0"}, g0, e0);
    chk({tag, "_byte1"}, g1, e1);
    chk({tag, "_byte2"}, g2, e2);
    chk({tag, "_vec_count"}, vec_count, vec_exp);
  endtask

  initial begin
    int n;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs", {rx_ready, tx_valid, tx_data, Din_emu, Addr_emu, load_emu, get_emu,
                          dut_step, busy}, 32'd0);
    chk("reset_vec_count", vec_count, 16'd0);
    repeat (3) @(posedge clk_emu);
    #1 rst_n = 1'b1;

    run_vec("basic", 8'h01, 8'h00, 8'h00, 8'h05, 0, 0, 8'h00, 8'h00, 8'h06);
    run_vec("midnight_gaps", 8'h01, 8'h17, 8'h3B, 8'h3B, 1, 0, 8'h00, 8'h00, 8'h00);
    run_vec("count_off", 8'h00, 8'h0C, 8'h22, 8'h38, 0, 0, 8'h0C, 8'h22, 8'h38);

    pat_mode = 1'b1;
    run_vec("readback_stall", 8'h5A, 8'hA5, 8'h3C, 8'hC3, 0, 10, 8'hA0, 8'hA1, 8'hA2);
    pat_mode = 1'b0;

    // Abort a vector while it is settling; the partial vector must vanish.
    send_vec(8'h01, 8'h02, 8'h03, 8'h04, 0);
    n = 0;
    while (!dut_step && n < 50) begin @(posedge clk_emu); #1; n++; end
    chk("reach_step", 32'(dut_step), 32'd1);
    repeat (2) begin @(posedge clk_emu); #1; end
    chk("busy_in_settle", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {rx_ready, tx_valid, tx_data, Din_emu, Addr_emu, load_emu, get_emu,
                           dut_step, busy}, 32'd0);
    chk("midrst_vec_count", vec_count, 16'd0);
    vec_exp = 16'd0;
    repeat (3) @(posedge clk_emu);
    #1 rst_n = 1'b1;
    run_vec("after_reset", 8'h01, 8'h01, 8'h02, 8'h03, 0, 0, 8'h01, 8'h02, 8'h04);

    force dut.vec_count_reg = 16'hFFFF;
    #1 release dut.vec_count_reg;
    chk("vec_preload", vec_count, 16'hFFFF);
    vec_exp = 16'hFFFF;
    run_vec("wrap", 8'h00, 8'h05, 8'h06, 8'h07, 0, 0, 8'h05, 8'h06, 8'h07);

    repeat (5) @(posedge clk_emu);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
